// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART byte serializer among NUM_REQ sources.
// Optional stall timeout on an owner that goes quiet mid-packet: define UART_ARB_TIMEOUT_EN.
module uart_tx_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_start_o,
  input  logic                      tx_busy_i,
  output logic                      timeout_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, START, DRAIN} state_t;

  state_t               r_state, w_state_nx;
  logic [IW-1:0]        r_ptr, r_gidx, w_win, w_cand;
  logic [NUM_REQ-1:0]   r_grant;
  logic [DATA_W-1:0]    r_tx_data;
  logic                 r_tx_start, r_last, r_timeout;
  logic                 w_any, w_xfer, w_to;
  int                   w_idx;

  // Search ptr+1, ptr+2, ... with an explicit wrap so non-power-of-2 counts rotate correctly.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_ptr;
    w_idx  = 0;
    w_cand = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = IW'(w_idx);
      if (!w_any && req_valid_i[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_xfer      = (r_state == LOAD) && !tx_busy_i && req_valid_i[r_gidx];
  assign req_ready_o = ((r_state == LOAD) && !tx_busy_i) ? (r_grant & req_valid_i) : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                      r_cnt <= '0;
    else if (r_state != LOAD || req_valid_i[r_gidx]) r_cnt <= '0;
    else                                            r_cnt <= r_cnt + 1'b1;
  end

  assign w_to = (r_state == LOAD) && !req_valid_i[r_gidx] && (r_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC > 0);
  assign w_to        = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nx = LOAD;
      LOAD:    if (w_to) w_state_nx = IDLE;
               else if (w_xfer) w_state_nx = START;
      START:   if (tx_busy_i) w_state_nx = DRAIN;
      DRAIN:   if (!tx_busy_i) w_state_nx = r_last ? IDLE : LOAD;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= IW'(NUM_REQ - 1);
      r_gidx     <= '0;
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_last     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_to;
      if (r_state == IDLE && w_any) begin
        r_gidx  <= w_win;
        r_grant <= NUM_REQ'(1) << w_win;
      end
      if (w_xfer) begin
        r_tx_data  <= req_data_i[r_gidx*DATA_W +: DATA_W];
        r_last     <= req_last_i[r_gidx];
        r_tx_start <= 1'b1;
      end
      if (r_state == START && tx_busy_i) r_tx_start <= 1'b0;
      // Owner released after its last byte has left the serializer, or when revoked.
      if ((r_state == DRAIN && !tx_busy_i && r_last) || w_to) begin
        r_ptr   <= r_gidx;
        r_grant <= '0;
      end
    end
  end

  assign grant_o    = r_grant;
  assign tx_data_o  = r_tx_data;
  assign tx_start_o = r_tx_start;
  assign timeout_o  = r_timeout;
endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Bench for uart_tx_rr_arbiter: directed scenarios plus random packets checked against a
// queue-level round-robin model and a serializer model. Honors UART_ARB_TIMEOUT_EN.
module tb_uart_tx_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_start, tx_busy, timeout;

  always #5 clk = ~clk;

  uart_tx_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready), .grant_o(grant), .tx_data_o(tx_data),
    .tx_start_o(tx_start), .tx_busy_i(tx_busy), .timeout_o(timeout));

  int          n_tests = 0, n_fail = 0;
  logic [8:0]  pq [N][128];
  int          hd [N], tl [N];
  bit          stall [N];
  bit          gaps_on, ser_auto;
  int          ser_cnt, ser_len, m_ptr, n_to;
  logic [7:0]  cap[$], exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic l);
    pq[k][tl[k]] = {l, b};
    tl[k]++;
  endtask

  // Requesters present their queue head; optional random valid gaps only inside a packet.
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bit pend, first, g;
      pend  = hd[k] < tl[k];
      first = 1'b1;
      if (pend && hd[k] > 0) first = pq[k][hd[k]-1][8];
      g = gaps_on && !first && ($urandom_range(3) == 0);
      req_valid[k]       = pend && !g && !stall[k];
      req_data[k*DW +: DW] = pend ? pq[k][hd[k]][7:0] : 8'h00;
      req_last[k]        = pend && pq[k][hd[k]][8];
    end
  endtask

  task automatic step();
    logic [N-1:0] xf;
    xf = req_valid & req_ready;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) if (xf[k]) hd[k]++;
    if (ser_auto) begin
      if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) tx_busy = 1'b0;
      end else if (tx_start) begin
        tx_busy = 1'b1;
        ser_cnt = ser_len;
        cap.push_back(tx_data);
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    if (timeout) n_to++;
`else
    chk("no_timeout", timeout, 0);
`endif
    chk("grant_onehot0", $onehot0(grant), 1);
    drive();
    #1;
    chk("ready_within_grant", req_ready & ~grant, 0);
  endtask

  // Reference: whole packets served in rotation over non-empty queues after the last owner.
  task automatic build_expect();
    int h [N];
    int k;
    bit found, l;
    k = 0;
    for (int i = 0; i < N; i++) h[i] = hd[i];
    forever begin
      found = 1'b0;
      for (int off = 1; off <= N && !found; off++) begin
        k = (m_ptr + off) % N;
        if (h[k] < tl[k]) found = 1'b1;
      end
      if (!found) break;
      do begin
        exp_q.push_back(pq[k][h[k]][7:0]);
        l = pq[k][h[k]][8];
        h[k]++;
      end while (!l && h[k] < tl[k]);
      m_ptr = k;
    end
  endtask

  task automatic run_drain(input string tag, input int budget);
    int c;
    bit done;
    c = 0; done = 1'b0;
    while (!done && c < budget) begin
      step(); c++;
      done = 1'b1;
      for (int k = 0; k < N; k++) if (hd[k] < tl[k]) done = 1'b0;
      if (grant != 0 || tx_busy || tx_start) done = 1'b0;
    end
    chk({tag, "_drained"}, done, 1);
    chk({tag, "_byte_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk({tag, "_byte"}, cap[i], exp_q[i]);
    cap.delete(); exp_q.delete();
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = N - 1;
  endtask

  initial begin
    int c;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    ser_auto = 1'b1; ser_cnt = 0; ser_len = 10; gaps_on = 1'b0; m_ptr = N - 1; n_to = 0;
    for (int k = 0; k < N; k++) begin hd[k] = 0; tl[k] = 0; stall[k] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;

    // Single requester, two bytes, latency of grant / ready / start
    push(1, 8'h55, 1'b0); push(1, 8'hA3, 1'b1);
    build_expect(); drive(); #1;
    chk("t1_ready_idle", req_ready, 0);
    step();
    chk("t1_grant", grant, 4'b0010);
    chk("t1_ready", req_ready, 4'b0010);
    step();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'h55);
    run_drain("t1", 200);
    chk("t1_grant_end", grant, 0);

    // Contention after reset: 0,1,2,3 then 0,2
    pulse_reset();
    for (int k = 0; k < N; k++) push(k, 8'(8'h20 + k), 1'b1);
    build_expect();
    chk("t2_model_first", exp_q[0], 8'h20);
    drive(); #1;
    run_drain("t2a", 400);
    push(2, 8'h42, 1'b1); push(0, 8'h40, 1'b1);
    build_expect(); drive(); #1;
    run_drain("t2b", 300);

    // Packet lock: req0 three bytes while req1 waits
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b0); push(0, 8'hB2, 1'b1); push(1, 8'hC1, 1'b1);
    build_expect(); drive(); #1;
    run_drain("t3", 400);

    // Back-pressure: serializer busy for 50 cycles while in LOAD
    ser_auto = 1'b0; tx_busy = 1'b1;
    push(3, 8'h3C, 1'b1);
    build_expect(); drive(); #1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("t4_ready_held", req_ready, 0);
      chk("t4_start_held", tx_start, 0);
    end
    chk("t4_grant", grant, 4'b1000);
    tx_busy = 1'b0; ser_auto = 1'b1; ser_cnt = 0; #1;
    chk("t4_ready_release", req_ready, 4'b1000);
    step();
    chk("t4_start_release", tx_start, 1);
    run_drain("t4", 100);

    // Reset while the second of four bytes drains
    ser_len = 8;
    push(0, 8'hD0, 1'b0); push(0, 8'hD1, 1'b0); push(0, 8'hD2, 1'b0); push(0, 8'hD3, 1'b1);
    push(1, 8'hE1, 1'b1);
    drive(); #1;
    c = 0;
    while (!(cap.size() == 2 && !tx_start && tx_busy) && c < 300) begin step(); c++; end
    chk("t5_reached_drain", c < 300, 1);
    rst = 1'b1; #1;
    chk("t5_grant", grant, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_start", tx_start, 0);
    chk("t5_data", tx_data, 0);
    chk("t5_timeout", timeout, 0);
    @(posedge clk); #1;
    rst = 1'b0; m_ptr = N - 1;
    hd[0] = tl[0];
    cap.delete(); exp_q.delete();
    push(0, 8'hF0, 1'b1);
    build_expect(); drive(); #1;
    step();
    chk("t5_req0_first", grant, 4'b0001);
    run_drain("t5", 400);

    // Owner drops valid mid-packet
    push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b1); push(3, 8'h81, 1'b1);
    drive(); #1;
    c = 0;
    while (hd[2] < 1 && c < 100) begin step(); c++; end
    stall[2] = 1'b1; drive(); #1;
`ifdef UART_ARB_TIMEOUT_EN
    n_to = 0; c = 0;
    while (n_to == 0 && c < 60) begin step(); c++; end
    chk("t6_timeout_pulse", n_to, 1);
    stall[2] = 1'b0;
    exp_q = '{8'h71, 8'h81, 8'h72};
    m_ptr = 2;
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t6_grant_held", grant, 4'b0100);
      chk("t6_req3_blocked", req_ready[3], 0);
    end
    stall[2] = 1'b0;
    exp_q = '{8'h71, 8'h72, 8'h81};
    m_ptr = 3;
`endif
    drive(); #1;
    run_drain("t6", 400);

    // Random packets, serializer lengths and mid-packet valid gaps
    gaps_on = 1'b1;
    for (int r = 0; r < 8; r++) begin
      ser_len = $urandom_range(12, 1);
      for (int k = 0; k < N; k++) begin
        int np;
        np = $urandom_range(2, 0);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len - 1);
        end
      end
      build_expect(); drive(); #1;
      run_drain("rand", 3000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
